// File: rtl/param_prog_counter_pkg.sv
// prog_counter_pkg: shared types and constants for param_prog_counter.
//   mode_e       - terminal-count behaviour (wrap / saturate / one-shot)
//   decode_mode  - maps the raw 2-bit mode pins onto mode_e; code 3 acts as wrap
//   RST_*        - reset values of the single-bit flags
package prog_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2
  } mode_e;

  localparam logic RST_TC   = 1'b0;
  localparam logic RST_OVF  = 1'b0;
  localparam logic RST_DONE = 1'b0;

  // The unused encoding falls back to wrap so the pins never select an
  // undefined behaviour.
  function automatic mode_e decode_mode(input logic [1:0] m);
    mode_e r;
    case (m)
      2'd1:    r = MODE_SAT;
      2'd2:    r = MODE_ONESHOT;
      default: r = MODE_WRAP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/param_prog_counter_tick_prescaler.sv
// tick_prescaler: divides enabled cycles down to one tick per div+1 cycles.
//   clk, rst_n - clock, synchronous active-low reset
//   en         - advances the prescaler; low holds its phase
//   sync_clr   - restarts the period (counter clear or load)
//   div        - divide field; 0 ticks on every enabled cycle
//   tick       - combinational, high in the cycle the counter should step
module tick_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [PRE_W-1:0] div,
  output logic             tick
);

  logic [PRE_W-1:0] pre;

  // If div is lowered below the current phase, pre keeps counting and wraps
  // through 2^PRE_W before matching again.
  assign tick = en & ~sync_clr & (pre == div);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (sync_clr) begin
      pre <= '0;
    end else if (en) begin
      pre <= tick ? '0 : pre + PRE_W'(1);
    end
  end

endmodule

// File: rtl/param_prog_counter.sv
// param_prog_counter: programmable up/down counter with modulo limit,
// prescaler and wrap / saturate / one-shot terminal behaviour.
//   clk, rst_n       - clock, synchronous active-low reset
//   en, dir          - count enable, direction (1 = up)
//   clr, load        - synchronous clear / load from load_data (clr wins)
//   lim_we           - write limit register from load_data
//   div              - prescale, one step per div+1 enabled cycles
//   mode             - 0 wrap, 1 saturate, 2 one-shot, 3 wrap
//   oe               - gates count; mirrored on count_oe for the pad
//   count            - counter value, zero when oe=0
//   tc               - one-cycle pulse after a terminal tick
//   ovf, done        - sticky wrap flag, sticky one-shot finished flag
module param_prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic             lim_we,
  input  logic [WIDTH-1:0] load_data,
  input  logic [PRE_W-1:0] div,
  input  logic [1:0]       mode,
  input  logic             oe,
  output logic [WIDTH-1:0] count,
  output logic             count_oe,
  output logic             tc,
  output logic             ovf,
  output logic             done
);

  logic [WIDTH-1:0] cnt, cnt_d, limit;
  logic             tc_d, ovf_d, done_d;
  logic             tick, terminal;
  mode_e            mode_sel;

  tick_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (clr | load),
    .div      (div),
    .tick     (tick)
  );

  assign mode_sel = decode_mode(mode);
  // ">=" so a value loaded above the limit is caught on the next tick.
  assign terminal = dir ? (cnt >= limit) : (cnt == '0);

  always_comb begin
    cnt_d  = cnt;
    tc_d   = 1'b0;
    ovf_d  = ovf;
    done_d = done;
    if (clr) begin
      cnt_d  = '0;
      ovf_d  = 1'b0;
      done_d = 1'b0;
    end else if (load) begin
      cnt_d  = load_data;
      ovf_d  = 1'b0;
      done_d = 1'b0;
    end else if (tick && !done) begin
      if (!terminal) begin
        cnt_d = dir ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
      end else begin
        tc_d = 1'b1;
        case (mode_sel)
          MODE_SAT:     cnt_d = cnt;
          MODE_ONESHOT: done_d = 1'b1;
          default: begin
            cnt_d = dir ? '0 : limit;
            ovf_d = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      tc   <= RST_TC;
      ovf  <= RST_OVF;
      done <= RST_DONE;
    end else begin
      cnt  <= cnt_d;
      tc   <= tc_d;
      ovf  <= ovf_d;
      done <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      limit <= '1;
    end else if (lim_we) begin
      limit <= load_data;
    end
  end

  assign count    = oe ? cnt : '0;
  assign count_oe = oe;

endmodule
